// File: rtl/lab2_proc_mem_responder.sv
// Single-outstanding-request word memory behind a val/rdy request/response pair,
// returning each response after a fixed, parameterised number of idle cycles.
module lab2_proc_mem_responder #(
    parameter int unsigned p_mem_words = 256,
    parameter int unsigned p_latency   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [2:0]  memreq_type,
    input  logic [7:0]  memreq_opaque,
    input  logic [31:0] memreq_addr,
    input  logic [1:0]  memreq_len,
    input  logic [31:0] memreq_data,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic [2:0]  memresp_type,
    output logic [7:0]  memresp_opaque,
    output logic [1:0]  memresp_len,
    output logic [31:0] memresp_data,
    output logic [31:0] num_reqs,
    output logic        oob_err
);

    localparam int unsigned IDX_W  = $clog2(p_mem_words);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_req_rdy;
    logic                r_resp_val;
    logic [2:0]          r_resp_type;
    logic [7:0]          r_resp_opaque;
    logic [1:0]          r_resp_len;
    logic [DATA_W-1:0]   r_resp_data;
    logic [31:0]         r_num_reqs;
    logic                r_oob_err;
    logic [DATA_W-1:0]   r_mem [0:p_mem_words-1];

    logic                w_accept;
    logic [29:0]         w_word_addr;
    logic [IDX_W-1:0]    w_idx;
    logic [1:0]          w_offset;
    logic                w_oob;
    logic                w_is_rd;
    logic                w_is_wr;
    logic [3:0]          w_len_mask;
    logic [DATA_W-1:0]   w_data_mask;
    logic [3:0]          w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_rword;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   w_resp_data;

    assign w_accept    = (r_state == S_IDLE) && r_req_rdy && memreq_val;
    assign w_word_addr = memreq_addr[31:2];
    assign w_idx       = memreq_addr[IDX_W+1:2];
    assign w_offset    = memreq_addr[1:0];
    assign w_oob       = 32'(w_word_addr) >= 32'(p_mem_words);
    assign w_is_rd     = (memreq_type == 3'd0);
    assign w_is_wr     = (memreq_type == 3'd1) || (memreq_type == 3'd2);

    // Lane/byte masks for the requested length; len 0 means a full word
    always_comb begin
        w_len_mask  = 4'b1111;
        w_data_mask = 32'hFFFF_FFFF;
        case (memreq_len)
            2'd1: begin
                w_len_mask  = 4'b0001;
                w_data_mask = 32'h0000_00FF;
            end
            2'd2: begin
                w_len_mask  = 4'b0011;
                w_data_mask = 32'h0000_FFFF;
            end
            2'd3: begin
                w_len_mask  = 4'b0111;
                w_data_mask = 32'h00FF_FFFF;
            end
            default: begin
                w_len_mask  = 4'b1111;
                w_data_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    // Shifting within a fixed 4-lane word drops lanes past byte 3 instead of wrapping
    assign w_be        = w_len_mask << w_offset;
    assign w_wdata     = memreq_data << {w_offset, 3'b000};
    assign w_rword     = w_oob ? '0 : r_mem[w_idx];
    assign w_rdata     = (w_rword >> {w_offset, 3'b000}) & w_data_mask;
    assign w_resp_data = w_is_rd ? w_rdata : '0;

    // Array is deliberately left out of reset; writes commit at acceptance
    always_ff @(posedge clk) begin
        if (w_accept && w_is_wr && !w_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request/response sequencing; rdy is a registered decode of the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_req_rdy     <= 1'b0;
            r_resp_val    <= 1'b0;
            r_resp_type   <= '0;
            r_resp_opaque <= '0;
            r_resp_len    <= '0;
            r_resp_data   <= '0;
            r_num_reqs    <= '0;
            r_oob_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_rdy <= 1'b1;
                    if (w_accept) begin
                        r_req_rdy     <= 1'b0;
                        r_resp_type   <= memreq_type;
                        r_resp_opaque <= memreq_opaque;
                        r_resp_len    <= memreq_len;
                        r_resp_data   <= w_resp_data;
                        r_num_reqs    <= r_num_reqs + 32'd1;
                        if (w_oob && (w_is_rd || w_is_wr)) begin
                            r_oob_err <= 1'b1;
                        end
                        if (p_latency == 0) begin
                            r_state    <= S_RESP;
                            r_resp_val <= 1'b1;
                        end else begin
                            r_cnt   <= CNT_W'(p_latency);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state    <= S_RESP;
                        r_resp_val <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (memresp_rdy) begin
                        r_state    <= S_IDLE;
                        r_resp_val <= 1'b0;
                        r_req_rdy  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_resp_val <= 1'b0;
                    r_req_rdy  <= 1'b0;
                end
            endcase
        end
    end

    assign memreq_rdy     = r_req_rdy;
    assign memresp_val    = r_resp_val;
    assign memresp_type   = r_resp_type;
    assign memresp_opaque = r_resp_opaque;
    assign memresp_len    = r_resp_len;
    assign memresp_data   = r_resp_data;
    assign num_reqs       = r_num_reqs;
    assign oob_err        = r_oob_err;

endmodule

// File: tb/tb_lab2_proc_mem_responder.sv
// Directed bench: one responder with zero latency and one with latency 3,
// sharing request fields; sel chooses which instance is being exercised.
module tb_lab2_proc_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_val;
    logic [2:0]  req_type;
    logic [7:0]  req_opaque;
    logic [31:0] req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_data;
    logic        resp_rdy;

    logic        rdy0, val0, oob0;
    logic [2:0]  type0;
    logic [7:0]  op0;
    logic [1:0]  len0;
    logic [31:0] data0, nreq0;
    logic        rdy3, val3, oob3;
    logic [2:0]  type3;
    logic [7:0]  op3;
    logic [1:0]  len3;
    logic [31:0] data3, nreq3;

    logic        m_rdy, m_val;
    logic [2:0]  m_type;
    logic [7:0]  m_op;
    logic [1:0]  m_len;
    logic [31:0] m_data;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    lab2_proc_mem_responder #(.p_mem_words(256), .p_latency(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .memreq_val(req_val & ~sel), .memreq_rdy(rdy0),
        .memreq_type(req_type), .memreq_opaque(req_opaque), .memreq_addr(req_addr),
        .memreq_len(req_len), .memreq_data(req_data),
        .memresp_val(val0), .memresp_rdy(resp_rdy),
        .memresp_type(type0), .memresp_opaque(op0), .memresp_len(len0),
        .memresp_data(data0), .num_reqs(nreq0), .oob_err(oob0)
    );

    lab2_proc_mem_responder #(.p_mem_words(256), .p_latency(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .memreq_val(req_val & sel), .memreq_rdy(rdy3),
        .memreq_type(req_type), .memreq_opaque(req_opaque), .memreq_addr(req_addr),
        .memreq_len(req_len), .memreq_data(req_data),
        .memresp_val(val3), .memresp_rdy(resp_rdy),
        .memresp_type(type3), .memresp_opaque(op3), .memresp_len(len3),
        .memresp_data(data3), .num_reqs(nreq3), .oob_err(oob3)
    );

    assign m_rdy  = sel ? rdy3  : rdy0;
    assign m_val  = sel ? val3  : val0;
    assign m_type = sel ? type3 : type0;
    assign m_op   = sel ? op3   : op0;
    assign m_len  = sel ? len3  : len0;
    assign m_data = sel ? data3 : data0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        assert (obs === expd) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expd);
        end
    endtask

    // Present a request and hold it until accepted; returns 1ns after the accepting edge
    task automatic do_req(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                          input logic [1:0] l, input logic [31:0] d);
        bit done = 1'b0;
        req_type = t; req_opaque = op; req_addr = a; req_len = l; req_data = d;
        req_val  = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            if (m_rdy) done = 1'b1;
            @(posedge clk);
            #1;
        end
        req_val = 1'b0;
        check("req_accept", 32'(done), 32'd1);
    endtask

    task automatic get_resp(output logic [2:0] t, output logic [7:0] op,
                            output logic [1:0] l, output logic [31:0] d);
        bit got = 1'b0;
        t = '0; op = '0; l = '0; d = '0;
        resp_rdy = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (m_val) begin
                t = m_type; op = m_op; l = m_len; d = m_data;
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        resp_rdy = 1'b0;
        check("resp_seen", 32'(got), 32'd1);
    endtask

    task automatic txn(input string tag, input logic [2:0] t, input logic [7:0] op,
                       input logic [31:0] a, input logic [1:0] l, input logic [31:0] d,
                       input logic [31:0] expd);
        logic [2:0]  rt;
        logic [7:0]  ro;
        logic [1:0]  rl;
        logic [31:0] rd;
        do_req(t, op, a, l, d);
        get_resp(rt, ro, rl, rd);
        check({tag, "_data"}, rd, expd);
        check({tag, "_opq"},  32'(ro), 32'(op));
        check({tag, "_type"}, 32'(rt), 32'(t));
        check({tag, "_len"},  32'(rl), 32'(l));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rt;
        logic [7:0]  ro;
        logic [1:0]  rl;
        logic [31:0] rd;

        reset = 1'b0; sel = 1'b0; req_val = 1'b0; resp_rdy = 1'b0;
        req_type = '0; req_opaque = '0; req_addr = '0; req_len = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy0", 32'(rdy0), 32'd0);
        check("rst_val0", 32'(val0), 32'd0);
        check("rst_rdy3", 32'(rdy3), 32'd0);
        check("rst_nreq0", nreq0, 32'd0);
        check("rst_oob0", 32'(oob0), 32'd0);
        check("rst_data3", data3, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rdy0", 32'(rdy0), 32'd1);

        // Zero-latency write then read-back
        do_req(3'd1, 8'h05, 32'h10, 2'd0, 32'hDEAD_BEEF);
        check("t1_val_next_cycle", 32'(m_val), 32'd1);
        check("t1_rdy_low", 32'(m_rdy), 32'd0);
        get_resp(rt, ro, rl, rd);
        check("t1_wr_type", 32'(rt), 32'd1);
        check("t1_wr_opq", 32'(ro), 32'h05);
        check("t1_wr_data", rd, 32'd0);
        txn("t1_rd", 3'd0, 8'h06, 32'h10, 2'd0, 32'h0, 32'hDEAD_BEEF);
        check("t1_nreq", nreq0, 32'd2);

        // Sub-word reads and writes, lanes past byte 3 dropped
        txn("t2_init20", 3'd2, 8'h10, 32'h20, 2'd0, 32'h1122_3344, 32'h0);
        txn("t2_init24", 3'd2, 8'h11, 32'h24, 2'd0, 32'h5566_7788, 32'h0);
        txn("t2_rd21l1", 3'd0, 8'h12, 32'h21, 2'd1, 32'h0, 32'h0000_0033);
        txn("t2_rd22l2", 3'd0, 8'h13, 32'h22, 2'd2, 32'h0, 32'h0000_1122);
        txn("t2_wr23l1", 3'd1, 8'h14, 32'h23, 2'd1, 32'h0000_00AA, 32'h0);
        txn("t2_rd20", 3'd0, 8'h15, 32'h20, 2'd0, 32'h0, 32'hAA22_3344);
        txn("t2_wr22l3", 3'd1, 8'h16, 32'h22, 2'd3, 32'h00CC_BBAA, 32'h0);
        txn("t2_rd20b", 3'd0, 8'h17, 32'h20, 2'd0, 32'h0, 32'hBBAA_3344);
        txn("t2_rd24", 3'd0, 8'h18, 32'h24, 2'd0, 32'h0, 32'h5566_7788);
        txn("t2_rd23l3", 3'd0, 8'h19, 32'h23, 2'd3, 32'h0, 32'h0000_00BB);
        txn("t2_unsup", 3'd3, 8'h1A, 32'h20, 2'd0, 32'hFFFF_FFFF, 32'h0);
        txn("t2_rd20c", 3'd0, 8'h1B, 32'h20, 2'd0, 32'h0, 32'hBBAA_3344);
        txn("t2_rd21l0", 3'd0, 8'h1C, 32'h21, 2'd0, 32'h0, 32'h00BB_AA33);
        check("t2_nreq", nreq0, 32'd15);

        // Latency 3: response appears on the fourth cycle after acceptance
        sel = 1'b1;
        #1;
        check("t3_nreq_before", nreq3, 32'd0);
        do_req(3'd1, 8'h33, 32'h30, 2'd0, 32'h1234_5678);
        check("t3_c1_val", 32'(m_val), 32'd0);
        check("t3_c1_rdy", 32'(m_rdy), 32'd0);
        @(posedge clk); #1;
        check("t3_c2_val", 32'(m_val), 32'd0);
        check("t3_c2_rdy", 32'(m_rdy), 32'd0);
        @(posedge clk); #1;
        check("t3_c3_val", 32'(m_val), 32'd0);
        @(posedge clk); #1;
        check("t3_c4_val", 32'(m_val), 32'd1);
        check("t3_nreq", nreq3, 32'd1);

        // Backpressure: response held, competing request ignored
        req_val = 1'b1; req_type = 3'd0; req_opaque = 8'hEE; req_addr = 32'h30; req_len = 2'd2;
        for (int i = 0; i < 5; i++) begin
            check("t4_val_hold", 32'(m_val), 32'd1);
            check("t4_rdy_low", 32'(m_rdy), 32'd0);
            check("t4_opq_stable", 32'(m_op), 32'h33);
            check("t4_len_stable", 32'(m_len), 32'd0);
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        check("t4_nreq_hold", nreq3, 32'd1);
        get_resp(rt, ro, rl, rd);
        check("t4_resp_opq", 32'(ro), 32'h33);
        check("t4_resp_data", rd, 32'd0);
        txn("t4_rd30", 3'd0, 8'h34, 32'h30, 2'd0, 32'h0, 32'h1234_5678);
        check("t4_nreq", nreq3, 32'd2);

        // Out-of-range accesses on the 256-word instance
        sel = 1'b0;
        #1;
        check("t5_oob_clear", 32'(oob0), 32'd0);
        txn("t5_init0", 3'd2, 8'h50, 32'h0, 2'd0, 32'h0BAD_F00D, 32'h0);
        txn("t5_wr3fc", 3'd1, 8'h51, 32'h3FC, 2'd0, 32'hCAFE_0001, 32'h0);
        txn("t5_rd3fc", 3'd0, 8'h52, 32'h3FC, 2'd0, 32'h0, 32'hCAFE_0001);
        check("t5_oob_top_ok", 32'(oob0), 32'd0);
        txn("t5_rd400", 3'd0, 8'h53, 32'h400, 2'd0, 32'h0, 32'h0);
        check("t5_oob_set", 32'(oob0), 32'd1);
        txn("t5_wr400", 3'd1, 8'h54, 32'h400, 2'd0, 32'hFFFF_FFFF, 32'h0);
        txn("t5_rd0", 3'd0, 8'h55, 32'h0, 2'd0, 32'h0, 32'h0BAD_F00D);
        check("t5_oob_sticky", 32'(oob0), 32'd1);

        // Reset during WAIT; the already-accepted write must persist
        sel = 1'b1;
        #1;
        txn("t6_wr40", 3'd1, 8'h60, 32'h40, 2'd0, 32'h600D_D00D, 32'h0);
        do_req(3'd1, 8'h61, 32'h44, 2'd0, 32'h0000_0077);
        check("t6_in_wait_val", 32'(m_val), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_val", 32'(val3), 32'd0);
        check("t6_rst_nreq", nreq3, 32'd0);
        check("t6_rst_rdy", 32'(rdy3), 32'd0);
        check("t6_rst_oob0", 32'(oob0), 32'd0);
        @(posedge clk); #1;
        check("t6_rst_rdy_hold", 32'(rdy3), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_idle_rdy", 32'(rdy3), 32'd1);
        check("t6_idle_val", 32'(val3), 32'd0);
        txn("t6_rd44", 3'd0, 8'h62, 32'h44, 2'd0, 32'h0, 32'h0000_0077);
        txn("t6_rd40", 3'd0, 8'h63, 32'h40, 2'd0, 32'h0, 32'h600D_D00D);
        check("t6_nreq", nreq3, 32'd2);
        sel = 1'b0;
        #1;
        txn("t6_rd3fc", 3'd0, 8'h64, 32'h3FC, 2'd0, 32'h0, 32'hCAFE_0001);
        check("t6_nreq0", nreq0, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
